// File: rtl/axi_master_burst_writer.sv
// AXI4 write master: splits one command into INCR bursts of at most MAX_BURST beats, one outstanding.
// Define AXI_WR_4K_SPLIT_EN to also cut bursts at 4096-byte address boundaries.
module axi_master_burst_writer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [LEN_WIDTH-1:0]    cmd_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [DATA_WIDTH-1:0]   src_data,
    input  logic                    src_empty,
    output logic                    src_pull,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [7:0]              AWLEN,
    output logic [2:0]              AWSIZE,
    output logic [1:0]              AWBURST,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WLAST,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int CW     = (LEN_WIDTH > 9) ? LEN_WIDTH : 9;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0]            AXSIZE     = 3'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << SIZE) - ADDR_WIDTH'(1));

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic [8:0]            r_blen;
    logic [8:0]            r_cnt;
    logic                  r_err;

    logic [CW-1:0] w_rem_ext;
    logic [8:0]    w_lim;
    logic [8:0]    w_blen;
    logic          w_in_aw;
    logic          w_in_w;
    logic          w_in_b;
    logic          w_wvalid;
    logic          w_wlast;
    logic          w_pull;
`ifdef AXI_WR_4K_SPLIT_EN
    logic [12:0]   w_to4k;
`endif

    // Length of the burst about to be issued; inputs are stable while in AW
    always_comb begin
        w_rem_ext = CW'(r_remaining);
        w_lim     = (w_rem_ext < CW'(MAX_BURST)) ? w_rem_ext[8:0] : 9'(MAX_BURST);
`ifdef AXI_WR_4K_SPLIT_EN
        w_to4k    = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> SIZE;
        w_blen    = ({4'd0, w_lim} > w_to4k) ? w_to4k[8:0] : w_lim;
`else
        w_blen    = w_lim;
`endif
    end

    assign w_in_aw  = (r_state == S_AW);
    assign w_in_w   = (r_state == S_W);
    assign w_in_b   = (r_state == S_B);
    assign w_wvalid = w_in_w & ~src_empty;
    assign w_wlast  = w_wvalid & (r_cnt == (r_blen - 9'd1));
    assign w_pull   = w_wvalid & WREADY;

    // Channel outputs are decoded from the state register so reset clears them at once
    assign AWVALID  = w_in_aw;
    assign AWADDR   = w_in_aw ? r_cur_addr : {ADDR_WIDTH{1'b0}};
    assign AWLEN    = w_in_aw ? 8'(w_blen - 9'd1) : 8'd0;
    assign AWSIZE   = w_in_aw ? AXSIZE : 3'd0;
    assign AWBURST  = w_in_aw ? 2'b01 : 2'b00;
    assign WVALID   = w_wvalid;
    assign WDATA    = w_in_w ? src_data : {DATA_WIDTH{1'b0}};
    assign WSTRB    = w_in_w ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
    assign WLAST    = w_wlast;
    assign src_pull = w_pull;
    assign BREADY   = w_in_b;
    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign err      = r_err;

    // Transfer sequencer: IDLE -> (AW -> W -> B)* -> DONE -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= {ADDR_WIDTH{1'b0}};
            r_remaining <= {LEN_WIDTH{1'b0}};
            r_blen      <= 9'd0;
            r_cnt       <= 9'd0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (cmd_beats != {LEN_WIDTH{1'b0}})) begin
                        r_cur_addr  <= cmd_addr & ALIGN_MASK;
                        r_remaining <= cmd_beats;
                        r_err       <= 1'b0;
                        r_state     <= S_AW;
                    end
                end
                S_AW: begin
                    if (AWREADY) begin
                        r_blen  <= w_blen;
                        r_cnt   <= 9'd0;
                        r_state <= S_W;
                    end
                end
                S_W: begin
                    if (w_pull) begin
                        r_cnt <= r_cnt + 9'd1;
                        if (w_wlast) begin
                            r_state <= S_B;
                        end
                    end
                end
                S_B: begin
                    // An error response is recorded but the remaining bursts still go out
                    if (BVALID) begin
                        r_err       <= r_err | (BRESP != 2'b00);
                        r_cur_addr  <= r_cur_addr + (ADDR_WIDTH'(r_blen) << SIZE);
                        r_remaining <= r_remaining - LEN_WIDTH'(r_blen);
                        r_state     <= (r_remaining == LEN_WIDTH'(r_blen)) ? S_DONE : S_AW;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_burst_writer.sv
// Directed bench for axi_master_burst_writer (DATA_WIDTH=32, MAX_BURST=16), with a reactive FIFO and AXI slave.
module tb_axi_master_burst_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_beats;
    logic        busy, done, err;
    logic [31:0] src_data;
    logic        src_empty;
    logic        src_pull;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST, WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;

    int checks = 0;
    int failures = 0;

    int aw_n = 0;
    int w_n = 0;
    int pull_n = 0;
    int done_n = 0;
    int b_n = 0;
    int err_b_idx = -1;
    logic [31:0] aw_addr_log [0:63];
    logic [7:0]  aw_len_log  [0:63];
    logic [2:0]  aw_size_log [0:63];
    logic [1:0]  aw_burst_log[0:63];
    logic [31:0] w_data_log  [0:255];
    logic        w_last_log  [0:255];

    axi_master_burst_writer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .busy(busy), .done(done), .err(err),
        .src_data(src_data), .src_empty(src_empty), .src_pull(src_pull),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    always #5 clk = ~clk;

    // FIFO head is a running word number; the selected burst gets SLVERR
    assign src_data = 32'hA500_0000 + 32'(pull_n);
    assign BRESP    = (b_n == err_b_idx) ? 2'b10 : 2'b00;

    // Handshake logger
    always @(posedge clk) begin
        if (AWVALID && AWREADY) begin
            aw_addr_log[aw_n[5:0]]  <= AWADDR;
            aw_len_log[aw_n[5:0]]   <= AWLEN;
            aw_size_log[aw_n[5:0]]  <= AWSIZE;
            aw_burst_log[aw_n[5:0]] <= AWBURST;
            aw_n <= aw_n + 1;
        end
        if (WVALID && WREADY) begin
            w_data_log[w_n[7:0]] <= WDATA;
            w_last_log[w_n[7:0]] <= WLAST;
            w_n <= w_n + 1;
        end
        if (src_pull) pull_n <= pull_n + 1;
        if (done) done_n <= done_n + 1;
        if (BVALID && BREADY) b_n <= b_n + 1;
    end

    // Issue one command; lat counts cycles after the start cycle until done is seen (-1 on timeout)
    task automatic run_cmd(input logic [31:0] a, input logic [15:0] n, input int budget,
                           output int lat, output logic err_at_done);
        @(negedge clk);
        cmd_addr = a; cmd_beats = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        err_at_done = err;
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cmd_addr = 32'd0; cmd_beats = 16'd0;
        src_empty = 1'b0; AWREADY = 1'b1; WREADY = 1'b1; BVALID = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, src_pull, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
             WDATA, WSTRB, WLAST, WVALID, BREADY} !== 89'd0) begin
            failures++;
            $display("FAIL reset_outputs: got AWSIZE=%0d AWBURST=%0d busy=%b BREADY=%b required all zero",
                     AWSIZE, AWBURST, busy, BREADY);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || AWVALID !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: got busy=%b AWVALID=%b required 0 0", busy, AWVALID);
        end
    endtask

    task automatic test_zero_beats;
        @(negedge clk);
        cmd_addr = 32'h80; cmd_beats = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || AWVALID !== 1'b0) begin
            failures++;
            $display("FAIL zero_beats_ignored: got busy=%b AWVALID=%b required 0 0", busy, AWVALID);
        end
    endtask

    task automatic test_single_burst;
        int a0, w0, p0, lat;
        logic e;
        a0 = aw_n; w0 = w_n; p0 = pull_n;
        run_cmd(32'h100, 16'd4, 50, lat, e);
        // start cycle plus 7 more = N+4 = 8 cycles
        checks++;
        if (lat !== 7) begin failures++; $display("FAIL single_latency: got %0d required 7", lat); end
        checks++;
        if (e !== 1'b0) begin failures++; $display("FAIL single_err: got %b required 0", e); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL single_done_pulse: got done=%b busy=%b required 0 0", done, busy);
        end
        checks++;
        if (aw_n - a0 !== 1 || aw_addr_log[a0[5:0]] !== 32'h100 || aw_len_log[a0[5:0]] !== 8'd3 ||
            aw_size_log[a0[5:0]] !== 3'd2 || aw_burst_log[a0[5:0]] !== 2'd1) begin
            failures++;
            $display("FAIL single_aw: got n=%0d addr=%h len=%0d size=%0d burst=%0d required 1 100 3 2 1",
                     aw_n - a0, aw_addr_log[a0[5:0]], aw_len_log[a0[5:0]], aw_size_log[a0[5:0]],
                     aw_burst_log[a0[5:0]]);
        end
        checks++;
        if (w_n - w0 !== 4) begin failures++; $display("FAIL single_wbeats: got %0d required 4", w_n - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w_data_log[(w0 + i) % 256] !== 32'hA500_0000 + 32'(p0 + i) ||
                w_last_log[(w0 + i) % 256] !== (i == 3)) begin
                failures++;
                $display("FAIL single_wbeat%0d: got data=%h last=%b required %h %b", i,
                         w_data_log[(w0 + i) % 256], w_last_log[(w0 + i) % 256],
                         32'hA500_0000 + 32'(p0 + i), (i == 3));
            end
        end
    endtask

    task automatic test_multi_burst;
        int a0, p0, d0, w0, lat, nlast;
        logic e;
        logic [31:0] exp_addr [0:2];
        logic [7:0]  exp_len  [0:2];
        exp_addr[0] = 32'h0;  exp_addr[1] = 32'h40; exp_addr[2] = 32'h80;
        exp_len[0]  = 8'd15;  exp_len[1]  = 8'd15;  exp_len[2]  = 8'd7;
        a0 = aw_n; p0 = pull_n; d0 = done_n; w0 = w_n;
        run_cmd(32'h0, 16'd40, 200, lat, e);
        checks++;
        if (lat !== 47) begin failures++; $display("FAIL multi_latency: got %0d required 47", lat); end
        @(negedge clk);
        checks++;
        if (aw_n - a0 !== 3) begin failures++; $display("FAIL multi_aw_count: got %0d required 3", aw_n - a0); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (aw_addr_log[(a0 + i) % 64] !== exp_addr[i] || aw_len_log[(a0 + i) % 64] !== exp_len[i]) begin
                failures++;
                $display("FAIL multi_aw%0d: got addr=%h len=%0d required %h %0d", i,
                         aw_addr_log[(a0 + i) % 64], aw_len_log[(a0 + i) % 64], exp_addr[i], exp_len[i]);
            end
        end
        checks++;
        if (pull_n - p0 !== 40) begin failures++; $display("FAIL multi_pulls: got %0d required 40", pull_n - p0); end
        checks++;
        if (done_n - d0 !== 1) begin failures++; $display("FAIL multi_done_count: got %0d required 1", done_n - d0); end
        nlast = 0;
        for (int i = 0; i < 40; i++) if (w_last_log[(w0 + i) % 256] === 1'b1) nlast++;
        checks++;
        if (nlast !== 3 || w_last_log[(w0 + 15) % 256] !== 1'b1 || w_last_log[(w0 + 39) % 256] !== 1'b1) begin
            failures++; $display("FAIL multi_wlast: got %0d WLAST beats required 3 at 15,31,39", nlast);
        end
    endtask

    task automatic test_4k_split;
        int a0, lat;
        logic e;
        a0 = aw_n;
        run_cmd(32'hFF8, 16'd8, 100, lat, e);
        @(negedge clk);
`ifdef AXI_WR_4K_SPLIT_EN
        checks++;
        if (lat !== 13 || aw_n - a0 !== 2) begin
            failures++; $display("FAIL split_count: got lat=%0d bursts=%0d required 13 2", lat, aw_n - a0);
        end
        checks++;
        if (aw_addr_log[a0 % 64] !== 32'hFF8 || aw_len_log[a0 % 64] !== 8'd1 ||
            aw_addr_log[(a0 + 1) % 64] !== 32'h1000 || aw_len_log[(a0 + 1) % 64] !== 8'd5) begin
            failures++;
            $display("FAIL split_bursts: got %h/%0d %h/%0d required FF8/1 1000/5",
                     aw_addr_log[a0 % 64], aw_len_log[a0 % 64],
                     aw_addr_log[(a0 + 1) % 64], aw_len_log[(a0 + 1) % 64]);
        end
`else
        checks++;
        if (lat !== 11 || aw_n - a0 !== 1) begin
            failures++; $display("FAIL nosplit_count: got lat=%0d bursts=%0d required 11 1", lat, aw_n - a0);
        end
        checks++;
        if (aw_addr_log[a0 % 64] !== 32'hFF8 || aw_len_log[a0 % 64] !== 8'd7) begin
            failures++;
            $display("FAIL nosplit_burst: got %h/%0d required FF8/7", aw_addr_log[a0 % 64], aw_len_log[a0 % 64]);
        end
`endif
    endtask

    task automatic test_backpressure;
        int a0, w0, p0, k;
        a0 = aw_n; w0 = w_n; p0 = pull_n;
        AWREADY = 1'b0;
        @(negedge clk);
        cmd_addr = 32'h200; cmd_beats = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (AWVALID !== 1'b1 || AWADDR !== 32'h200 || AWLEN !== 8'd7) begin
                failures++;
                $display("FAIL bp_aw_hold%0d: got valid=%b addr=%h len=%0d required 1 200 7", i, AWVALID, AWADDR, AWLEN);
            end
            @(negedge clk);
        end
        AWREADY = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        src_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (WVALID !== 1'b0 || src_pull !== 1'b0) begin
                failures++; $display("FAIL bp_starve%0d: got WVALID=%b pull=%b required 0 0", i, WVALID, src_pull);
            end
            @(negedge clk);
        end
        checks++;
        if (pull_n - p0 !== 2) begin failures++; $display("FAIL bp_starve_pulls: got %0d required 2", pull_n - p0); end
        src_empty = 1'b0;
        WREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (WVALID !== 1'b1 || WDATA !== 32'hA500_0000 + 32'(p0 + 2)) begin
                failures++;
                $display("FAIL bp_wdata_hold%0d: got valid=%b data=%h required 1 %h", i, WVALID, WDATA,
                         32'hA500_0000 + 32'(p0 + 2));
            end
            @(negedge clk);
        end
        WREADY = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL bp_done: got done=%b required 1", done); end
        @(negedge clk);
        checks++;
        if (pull_n - p0 !== 8 || aw_n - a0 !== 1) begin
            failures++; $display("FAIL bp_counts: got pulls=%0d bursts=%0d required 8 1", pull_n - p0, aw_n - a0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_data_log[(w0 + i) % 256] !== 32'hA500_0000 + 32'(p0 + i)) begin
                failures++;
                $display("FAIL bp_word%0d: got %h required %h", i, w_data_log[(w0 + i) % 256],
                         32'hA500_0000 + 32'(p0 + i));
            end
        end
    endtask

    task automatic test_error_response;
        int a0, p0, lat;
        logic e;
        a0 = aw_n; p0 = pull_n;
        err_b_idx = b_n;
        run_cmd(32'h400, 16'd20, 100, lat, e);
        checks++;
        if (lat === -1 || e !== 1'b1) begin failures++; $display("FAIL err_sticky: got lat=%0d err=%b required err 1", lat, e); end
        @(negedge clk);
        err_b_idx = -1;
        checks++;
        if (aw_n - a0 !== 2 || aw_len_log[a0 % 64] !== 8'd15 ||
            aw_addr_log[(a0 + 1) % 64] !== 32'h440 || aw_len_log[(a0 + 1) % 64] !== 8'd3) begin
            failures++;
            $display("FAIL err_second_burst: got n=%0d len0=%0d addr1=%h len1=%0d required 2 15 440 3",
                     aw_n - a0, aw_len_log[a0 % 64], aw_addr_log[(a0 + 1) % 64], aw_len_log[(a0 + 1) % 64]);
        end
        checks++;
        if (pull_n - p0 !== 20) begin failures++; $display("FAIL err_pulls: got %0d required 20", pull_n - p0); end
        run_cmd(32'h500, 16'd4, 50, lat, e);
        checks++;
        if (lat !== 7 || e !== 1'b0) begin
            failures++; $display("FAIL err_clean_cmd: got lat=%0d err=%b required 7 0", lat, e);
        end
    endtask

    task automatic test_reset_mid;
        int a0, w0, k, lat;
        logic e;
        w0 = w_n;
        @(negedge clk);
        cmd_addr = 32'h600; cmd_beats = 16'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (w_n - w0 < 2 && k < 50) begin @(negedge clk); k++; end
        checks++;
        if (w_n - w0 !== 2 || WVALID !== 1'b1) begin
            failures++; $display("FAIL rstmid_reach_beat3: got beats=%0d WVALID=%b required 2 1", w_n - w0, WVALID);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, src_pull, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
             WDATA, WSTRB, WLAST, WVALID, BREADY} !== 89'd0) begin
            failures++;
            $display("FAIL rstmid_outputs: got busy=%b WVALID=%b WSTRB=%h required all zero", busy, WVALID, WSTRB);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_idle: got busy=%b required 0", busy); end
        a0 = aw_n;
        run_cmd(32'h700, 16'd4, 50, lat, e);
        @(negedge clk);
        checks++;
        if (lat !== 7 || e !== 1'b0 || aw_n - a0 !== 1 ||
            aw_addr_log[a0 % 64] !== 32'h700 || aw_len_log[a0 % 64] !== 8'd3) begin
            failures++;
            $display("FAIL rstmid_recover: got lat=%0d err=%b n=%0d addr=%h len=%0d required 7 0 1 700 3",
                     lat, e, aw_n - a0, aw_addr_log[a0 % 64], aw_len_log[a0 % 64]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_beats();
        test_single_burst();
        test_multi_burst();
        test_4k_split();
        test_backpressure();
        test_error_response();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
